// File: rtl/axi_mm_pkg.sv
// Shared definitions for the axi_mm AXI4-Lite slave front-end.
package axi_mm_pkg;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWresp,
    StRd,
    StRcap,
    StRresp
  } state_e;

  typedef enum logic {
    GrantRd,
    GrantWr
  } grant_e;

  // Byte-offset bits dropped to form a memory word address.
  function automatic int unsigned addr_lsb(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi_mm_skid_slot.sv
// Single-entry holding register for one AXI request channel.
// Accepts one beat when empty and enabled, holds it until the owner clears it.
module axi_mm_skid_slot #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  input  logic             clr_i,
  output logic             ready_o,
  output logic             full_o,
  output logic [Width-1:0] data_o
);

  logic             full_d, full_q;
  logic [Width-1:0] data_d, data_q;

  assign ready_o = en_i & ~full_q;
  assign full_o  = full_q;
  assign data_o  = data_q;

  // Fill on handshake, empty when the consumer takes the entry.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clr_i) begin
      full_d = 1'b0;
    end else if (valid_i && ready_o) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  // Entry state, flushed by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/axi_mm_lite_slave_if.sv
// AXI4-Lite slave front-end for the axi_mm block-RAM wrapper: buffers AW/W/AR,
// arbitrates reads against writes onto one memory port and forms B/R responses.
module axi_mm_lite_slave_if
  import axi_mm_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 16,
  parameter int unsigned OPT_MEM_ADDR_BITS  = 10
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr_i,
  input  logic                            s_axi_awvalid_i,
  output logic                            s_axi_awready_o,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata_i,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb_i,
  input  logic                            s_axi_wvalid_i,
  output logic                            s_axi_wready_o,
  output logic [1:0]                      s_axi_bresp_o,
  output logic                            s_axi_bvalid_o,
  input  logic                            s_axi_bready_i,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr_i,
  input  logic                            s_axi_arvalid_i,
  output logic                            s_axi_arready_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata_o,
  output logic [1:0]                      s_axi_rresp_o,
  output logic                            s_axi_rvalid_o,
  input  logic                            s_axi_rready_i,
  output logic [OPT_MEM_ADDR_BITS:0]      mem_addr_o,
  output logic                            mem_wen_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] mem_wstrb_o,
  output logic                            mem_ren_o,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int unsigned DW      = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW      = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned StrbW   = DW / 8;
  localparam int unsigned MemAw   = OPT_MEM_ADDR_BITS + 1;
  localparam int unsigned AddrLsb = addr_lsb(DW);

  // Holds every ready low until the first clock after reset release.
  logic init_q;

  logic              aw_full, w_full, ar_full;
  logic [AW-1:0]     aw_addr, ar_addr;
  logic [DW+StrbW-1:0] w_buf;
  logic              ar_en;
  logic              wr_elig, rd_elig, grant_wr, grant_rd;
  logic              aw_oor, ar_oor;

  state_e             state_q;
  grant_e             last_grant_q;
  logic               wr_err_q, rd_err_q;
  logic [MemAw-1:0]   mem_addr_q;
  logic               mem_wen_q, mem_ren_q;
  logic [DW-1:0]      mem_wdata_q;
  logic [StrbW-1:0]   mem_wstrb_q;
  logic               bvalid_q, rvalid_q;
  logic [1:0]         bresp_q, rresp_q;
  logic [DW-1:0]      rdata_q;

  // AR is only taken while idle, so a read never queues behind its own response.
  assign ar_en = init_q & (state_q == StIdle);

  axi_mm_skid_slot #(.Width(AW)) u_aw_slot (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (init_q),
    .valid_i (s_axi_awvalid_i),
    .data_i  (s_axi_awaddr_i),
    .clr_i   (grant_wr),
    .ready_o (s_axi_awready_o),
    .full_o  (aw_full),
    .data_o  (aw_addr)
  );

  axi_mm_skid_slot #(.Width(DW + StrbW)) u_w_slot (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (init_q),
    .valid_i (s_axi_wvalid_i),
    .data_i  ({s_axi_wstrb_i, s_axi_wdata_i}),
    .clr_i   (grant_wr),
    .ready_o (s_axi_wready_o),
    .full_o  (w_full),
    .data_o  (w_buf)
  );

  axi_mm_skid_slot #(.Width(AW)) u_ar_slot (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (ar_en),
    .valid_i (s_axi_arvalid_i),
    .data_i  (s_axi_araddr_i),
    .clr_i   (grant_rd),
    .ready_o (s_axi_arready_o),
    .full_o  (ar_full),
    .data_o  (ar_addr)
  );

  // Range check and arbitration; on contention the side not served last wins.
  always_comb begin
    aw_oor   = |(aw_addr >> (AddrLsb + MemAw));
    ar_oor   = |(ar_addr >> (AddrLsb + MemAw));
    wr_elig  = aw_full & w_full;
    rd_elig  = ar_full;
    grant_wr = (state_q == StIdle) & wr_elig & (~rd_elig | (last_grant_q == GrantRd));
    grant_rd = (state_q == StIdle) & rd_elig & ~grant_wr;
  end

  // Post-reset enable for the request channels.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
    end
  end

  // Transaction FSM with registered memory strobes and response channels.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      last_grant_q <= GrantRd;
      wr_err_q     <= 1'b0;
      rd_err_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wen_q    <= 1'b0;
      mem_ren_q    <= 1'b0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RespOkay;
      rvalid_q     <= 1'b0;
      rresp_q      <= RespOkay;
      rdata_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_wr) begin
            mem_addr_q   <= aw_addr[AddrLsb +: MemAw];
            mem_wdata_q  <= w_buf[DW-1:0];
            mem_wstrb_q  <= w_buf[DW +: StrbW];
            mem_wen_q    <= ~aw_oor;
            wr_err_q     <= aw_oor;
            last_grant_q <= GrantWr;
            state_q      <= StWr;
          end else if (grant_rd) begin
            mem_addr_q   <= ar_addr[AddrLsb +: MemAw];
            mem_ren_q    <= ~ar_oor;
            rd_err_q     <= ar_oor;
            last_grant_q <= GrantRd;
            state_q      <= StRd;
          end
        end
        StWr: begin
          mem_wen_q <= 1'b0;
          bvalid_q  <= 1'b1;
          bresp_q   <= wr_err_q ? RespSlverr : RespOkay;
          state_q   <= StWresp;
        end
        StWresp: begin
          if (s_axi_bready_i) begin
            bvalid_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        StRd: begin
          mem_ren_q <= 1'b0;
          state_q   <= StRcap;
        end
        StRcap: begin
          rdata_q  <= rd_err_q ? '0 : mem_rdata_i;
          rresp_q  <= rd_err_q ? RespSlverr : RespOkay;
          rvalid_q <= 1'b1;
          state_q  <= StRresp;
        end
        StRresp: begin
          if (s_axi_rready_i) begin
            rvalid_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_addr_o     = mem_addr_q;
  assign mem_wen_o      = mem_wen_q;
  assign mem_ren_o      = mem_ren_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign mem_wstrb_o    = mem_wstrb_q;
  assign s_axi_bvalid_o = bvalid_q;
  assign s_axi_bresp_o  = bresp_q;
  assign s_axi_rvalid_o = rvalid_q;
  assign s_axi_rresp_o  = rresp_q;
  assign s_axi_rdata_o  = rdata_q;

endmodule

// File: tb/tb_axi_mm_lite_slave_if.sv
// Directed bench for axi_mm_lite_slave_if with a registered-read memory model.
module tb_axi_mm_lite_slave_if;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [15:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [10:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ren;
  logic [31:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;
  int wen_cnt = 0, ren_cnt = 0, both_cnt = 0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0;
  bit grant_log[$];
  logic [31:0] mem_model [0:2047];

  always #5 clk = ~clk;

  axi_mm_lite_slave_if #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (16),
    .OPT_MEM_ADDR_BITS  (10)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .s_axi_awaddr_i  (awaddr),
    .s_axi_awvalid_i (awvalid),
    .s_axi_awready_o (awready),
    .s_axi_wdata_i   (wdata),
    .s_axi_wstrb_i   (wstrb),
    .s_axi_wvalid_i  (wvalid),
    .s_axi_wready_o  (wready),
    .s_axi_bresp_o   (bresp),
    .s_axi_bvalid_o  (bvalid),
    .s_axi_bready_i  (bready),
    .s_axi_araddr_i  (araddr),
    .s_axi_arvalid_i (arvalid),
    .s_axi_arready_o (arready),
    .s_axi_rdata_o   (rdata),
    .s_axi_rresp_o   (rresp),
    .s_axi_rvalid_o  (rvalid),
    .s_axi_rready_i  (rready),
    .mem_addr_o      (mem_addr),
    .mem_wen_o       (mem_wen),
    .mem_wdata_o     (mem_wdata),
    .mem_wstrb_o     (mem_wstrb),
    .mem_ren_o       (mem_ren),
    .mem_rdata_i     (mem_rdata)
  );

  // Memory read port: data valid only the cycle after a read strobe.
  always @(posedge clk) begin
    mem_rdata <= mem_ren ? mem_model[mem_addr] : 32'hBAD0_BAD0;
  end

  // Strobe and handshake monitor.
  always @(posedge clk) begin
    if (mem_wen) begin wen_cnt++; grant_log.push_back(1'b1); end
    if (mem_ren) begin ren_cnt++; grant_log.push_back(1'b0); end
    if (mem_wen && mem_ren) both_cnt++;
    if (awvalid && awready) aw_hs++;
    if (wvalid && wready) w_hs++;
    if (arvalid && arready) ar_hs++;
  end

  task automatic wait_bvalid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bvalid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_rvalid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rvalid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({awready, wready, arready} !== 3'b000) begin
      errors++; $display("FAIL reset_ready: got %b expected 000", {awready, wready, arready}); end
    checks++; if ({bvalid, rvalid} !== 2'b00) begin
      errors++; $display("FAIL reset_valid: got %b expected 00", {bvalid, rvalid}); end
    checks++; if ({mem_wen, mem_ren} !== 2'b00) begin
      errors++; $display("FAIL reset_strobe: got %b expected 00", {mem_wen, mem_ren}); end
    checks++; if ({rdata, bresp, rresp} !== 36'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {rdata, bresp, rresp}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL post_reset_ready: got %b expected 111", {awready, wready, arready}); end
  endtask

  task automatic test_write_same_cycle();
    int c0 = wen_cnt;
    awaddr = 16'h0000; awvalid = 1'b1;
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    checks++; if ({awready, wready} !== 2'b00) begin
      errors++; $display("FAIL w1_ready_full: got %b expected 00", {awready, wready}); end
    @(negedge clk);
    checks++; if ({mem_wen, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 11'h0, 32'hDEAD_BEEF, 4'hF}) begin
      errors++; $display("FAIL w1_mem: got wen=%b addr=%h data=%h strb=%h expected 1 000 deadbeef f",
                         mem_wen, mem_addr, mem_wdata, mem_wstrb); end
    @(negedge clk);
    checks++; if ({mem_wen, bvalid, bresp} !== 4'b0100) begin
      errors++; $display("FAIL w1_bresp: got wen=%b bvalid=%b bresp=%b expected 0 1 00",
                         mem_wen, bvalid, bresp); end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checks++; if (bvalid !== 1'b0) begin
      errors++; $display("FAIL w1_bdone: got bvalid=%b expected 0", bvalid); end
    checks++; if (wen_cnt - c0 !== 1) begin
      errors++; $display("FAIL w1_pulses: got %0d expected 1", wen_cnt - c0); end
  endtask

  task automatic test_w_before_aw();
    int c0 = wen_cnt;
    wdata = 32'hA5A5_0001; wstrb = 4'h3; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    checks++; if (wready !== 1'b0) begin
      errors++; $display("FAIL w2_wready_full: got %b expected 0", wready); end
    @(negedge clk);
    checks++; if (wen_cnt != c0 || awready !== 1'b1) begin
      errors++; $display("FAIL w2_wait_aw: got pulses=%0d awready=%b expected 0 1",
                         wen_cnt - c0, awready); end
    awaddr = 16'h0008; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    checks++; if (awready !== 1'b0) begin
      errors++; $display("FAIL w2_awready_full: got %b expected 0", awready); end
    @(negedge clk);
    checks++; if ({mem_wen, mem_wstrb, mem_addr} !== {1'b1, 4'h3, 11'h002}) begin
      errors++; $display("FAIL w2_mem: got wen=%b strb=%h addr=%h expected 1 3 002",
                         mem_wen, mem_wstrb, mem_addr); end
    @(negedge clk);
    checks++; if ({bvalid, bresp} !== 3'b100) begin
      errors++; $display("FAIL w2_bresp: got bvalid=%b bresp=%b expected 1 00", bvalid, bresp); end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checks++; if (wen_cnt - c0 !== 1) begin
      errors++; $display("FAIL w2_pulses: got %0d expected 1", wen_cnt - c0); end
  endtask

  task automatic test_read_hold();
    int c0 = ren_cnt;
    araddr = 16'h0004; arvalid = 1'b1;
    checks++; if (arready !== 1'b1) begin
      errors++; $display("FAIL r3_arready: got %b expected 1", arready); end
    @(negedge clk);
    arvalid = 1'b0;
    checks++; if (arready !== 1'b0) begin
      errors++; $display("FAIL r3_arready_full: got %b expected 0", arready); end
    @(negedge clk);
    checks++; if ({mem_ren, mem_addr} !== {1'b1, 11'h001}) begin
      errors++; $display("FAIL r3_mem: got ren=%b addr=%h expected 1 001", mem_ren, mem_addr); end
    @(negedge clk);
    checks++; if (rvalid !== 1'b0) begin
      errors++; $display("FAIL r3_early_rvalid: got %b expected 0", rvalid); end
    @(negedge clk);
    checks++; if ({rvalid, rdata, rresp} !== {1'b1, 32'h1234_5678, 2'b00}) begin
      errors++; $display("FAIL r3_rdata: got rvalid=%b rdata=%h rresp=%b expected 1 12345678 00",
                         rvalid, rdata, rresp); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({rvalid, rdata, rresp} !== {1'b1, 32'h1234_5678, 2'b00}) begin
        errors++; $display("FAIL r3_hold%0d: got rvalid=%b rdata=%h expected 1 12345678",
                           i, rvalid, rdata); end
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    checks++; if (rvalid !== 1'b0 || ren_cnt - c0 != 1) begin
      errors++; $display("FAIL r3_done: got rvalid=%b pulses=%0d expected 0 1",
                         rvalid, ren_cnt - c0); end
  endtask

  task automatic test_back_to_back();
    int start = grant_log.size();
    int a0 = aw_hs, w0 = w_hs, r0 = ar_hs;
    logic got;
    bready = 1'b1; rready = 1'b1;
    for (int cyc = 0; cyc < 300 && (grant_log.size() - start) < 6; cyc++) begin
      awvalid = (aw_hs - a0) < 3;
      wvalid  = (w_hs - w0) < 3;
      arvalid = (ar_hs - r0) < 3;
      awaddr  = 16'h0010 + 16'(4 * (aw_hs - a0));
      wdata   = 32'h0000_1000 + 32'(aw_hs - a0);
      wstrb   = 4'hF;
      araddr  = 16'h0020 + 16'(4 * (ar_hs - r0));
      @(negedge clk);
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    repeat (8) @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      got = (start + i < grant_log.size()) ? logic'(grant_log[start + i]) : 1'bx;
      checks++; if (got !== ((i % 2) == 0)) begin
        errors++; $display("FAIL b2b_grant%0d: got %b expected %b (1=write)", i, got, (i % 2) == 0); end
    end
    checks++; if (both_cnt !== 0) begin
      errors++; $display("FAIL b2b_exclusive: got %0d overlaps expected 0", both_cnt); end
  endtask

  task automatic test_out_of_range();
    int c0 = wen_cnt;
    int r0;
    bit ok;
    awaddr = 16'h2000; awvalid = 1'b1;
    wdata = 32'h1111_2222; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    wait_bvalid(ok);
    checks++; if ({ok, bresp} !== 3'b110) begin
      errors++; $display("FAIL oor_bresp: got seen=%b bresp=%b expected 1 10", ok, bresp); end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checks++; if (wen_cnt != c0) begin
      errors++; $display("FAIL oor_no_wen: got %0d pulses expected 0", wen_cnt - c0); end
    r0 = ren_cnt;
    araddr = 16'h8004; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    wait_rvalid(ok);
    checks++; if ({ok, rresp, rdata} !== {1'b1, 2'b10, 32'h0}) begin
      errors++; $display("FAIL oor_rresp: got seen=%b rresp=%b rdata=%h expected 1 10 0",
                         ok, rresp, rdata); end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    checks++; if (ren_cnt != r0) begin
      errors++; $display("FAIL oor_no_ren: got %0d pulses expected 0", ren_cnt - r0); end
    // Highest in-range word must still read normally.
    araddr = 16'h1FFC; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    wait_rvalid(ok);
    checks++; if ({ok, rresp, rdata} !== {1'b1, 2'b00, 32'h7FF0_7FF0}) begin
      errors++; $display("FAIL top_word: got seen=%b rresp=%b rdata=%h expected 1 00 7ff07ff0",
                         ok, rresp, rdata); end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int r0;
    bit ok;
    araddr = 16'h0004; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    wait_rvalid(ok);
    checks++; if (ok !== 1'b1) begin
      errors++; $display("FAIL rst_pre_rvalid: got %b expected 1", ok); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({rvalid, bvalid} !== 2'b00) begin
      errors++; $display("FAIL rst_async_rvalid: got %b expected 00", {rvalid, bvalid}); end
    r0 = ren_cnt;
    repeat (2) @(negedge clk);
    checks++; if (arready !== 1'b0) begin
      errors++; $display("FAIL rst_arready: got %b expected 0", arready); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (arready !== 1'b1 || ren_cnt != r0) begin
      errors++; $display("FAIL rst_idle: got arready=%b pulses=%0d expected 1 0",
                         arready, ren_cnt - r0); end
    araddr = 16'h0008; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    wait_rvalid(ok);
    checks++; if ({ok, rresp, rdata} !== {1'b1, 2'b00, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL rst_next_read: got seen=%b rresp=%b rdata=%h expected 1 00 cafef00d",
                         ok, rresp, rdata); end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem_model[i] = 32'h5000_0000 + 32'(i);
    mem_model[1]    = 32'h1234_5678;
    mem_model[2]    = 32'hCAFE_F00D;
    mem_model[2047] = 32'h7FF0_7FF0;
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_read_hold();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
